// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the shared-ALU arbiter slice.
//   - 5-bit ALU op codes (ADD..AND)
//   - alu_op_legal(): legality of an op code for 64-bit or 32-bit (W) ops
//   - alu_rsp_t: one registered response (requester id, result, flags)
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_SLL  = 5'd2;
  localparam logic [4:0] ALU_SLT  = 5'd3;
  localparam logic [4:0] ALU_SLTU = 5'd4;
  localparam logic [4:0] ALU_XOR  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;
  localparam logic [4:0] ALU_SRA  = 5'd7;
  localparam logic [4:0] ALU_OR   = 5'd8;
  localparam logic [4:0] ALU_AND  = 5'd9;

  // The id field is sized for the largest supported requester count (4).
  localparam int MAX_ID_W = 2;

  typedef struct packed {
    logic [MAX_ID_W-1:0] id;
    logic [63:0]         result;
    logic                zero;
    logic                err;
  } alu_rsp_t;

  // W ops only exist for add/sub and the three shifts.
  function automatic logic alu_op_legal(input logic [4:0] code, input logic word_op);
    if (word_op) begin
      return (code == ALU_ADD) || (code == ALU_SUB) || (code == ALU_SLL) ||
             (code == ALU_SRL) || (code == ALU_SRA);
    end
    return (code <= ALU_AND);
  endfunction

endpackage

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu
// Purely combinational 64-bit ALU with 32-bit (W) variants whose results are
// sign-extended to 64 bits. Illegal op code / word_op combinations return 0
// and raise o_err.
// Ports:
//   i_operand_a, i_operand_b : 64-bit operands
//   i_alu_control            : op code (see alu_pkg)
//   i_word_op                : 1 = 32-bit W operation
//   o_result, o_zero, o_err  : result, result==0, illegal-op flag
// ---------------------------------------------------------------------------
module alu
  import alu_pkg::*;
(
  input  logic [63:0] i_operand_a,
  input  logic [63:0] i_operand_b,
  input  logic [4:0]  i_alu_control,
  input  logic        i_word_op,
  output logic [63:0] o_result,
  output logic        o_zero,
  output logic        o_err
);

  logic [31:0] w_a32;
  logic [31:0] w_b32;
  logic [31:0] w_res32;
  logic [63:0] w_res64;

  assign w_a32 = i_operand_a[31:0];
  assign w_b32 = i_operand_b[31:0];

  always_comb begin
    w_res32 = '0;
    w_res64 = '0;
    if (i_word_op) begin
      case (i_alu_control)
        ALU_ADD: w_res32 = w_a32 + w_b32;
        ALU_SUB: w_res32 = w_a32 - w_b32;
        ALU_SLL: w_res32 = w_a32 << w_b32[4:0];
        ALU_SRL: w_res32 = w_a32 >> w_b32[4:0];
        ALU_SRA: w_res32 = $signed(w_a32) >>> w_b32[4:0];
        default: w_res32 = '0;
      endcase
    end else begin
      case (i_alu_control)
        ALU_ADD:  w_res64 = i_operand_a + i_operand_b;
        ALU_SUB:  w_res64 = i_operand_a - i_operand_b;
        ALU_SLL:  w_res64 = i_operand_a << i_operand_b[5:0];
        ALU_SLT:  w_res64 = {63'd0, $signed(i_operand_a) < $signed(i_operand_b)};
        ALU_SLTU: w_res64 = {63'd0, i_operand_a < i_operand_b};
        ALU_XOR:  w_res64 = i_operand_a ^ i_operand_b;
        ALU_SRL:  w_res64 = i_operand_a >> i_operand_b[5:0];
        ALU_SRA:  w_res64 = $signed(i_operand_a) >>> i_operand_b[5:0];
        ALU_OR:   w_res64 = i_operand_a | i_operand_b;
        ALU_AND:  w_res64 = i_operand_a & i_operand_b;
        default:  w_res64 = '0;
      endcase
    end
  end

  assign o_result = i_word_op ? {{32{w_res32[31]}}, w_res32} : w_res64;
  assign o_zero   = (o_result == 64'd0);
  assign o_err    = !alu_op_legal(i_alu_control, i_word_op);

endmodule

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin search: grants the first set request starting at
// i_ptr and wrapping around. No grant at all when i_en is low.
// Ports:
//   i_req : request vector
//   i_ptr : highest-priority index this cycle
//   i_en  : grant enable
//   o_gnt : one-hot grant (or zero)
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_gnt
);

  // Search order: w_idx[k] is the requester examined at priority k.
  logic [ID_W-1:0] w_idx [NUM_REQ];
  logic            w_found;

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx[k] = ID_W'((int'(i_ptr) + k) % NUM_REQ);
    end
  end

  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (i_en && !w_found && i_req[w_idx[k]]) begin
        o_gnt[w_idx[k]] = 1'b1;
        w_found         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
// Shares one 64-bit ALU between NUM_REQ requesters. A round-robin arbiter
// grants one request per cycle into a single registered response slot.
//
// Handshakes: a transfer happens on a channel in any cycle where valid and
// ready are both high at the rising clock edge. req_ready is the one-hot grant
// and only depends on req_valid, the RR pointer, and slot_free
// (!rsp_valid || rsp_ready); the response slot may be drained and reloaded in
// the same cycle, giving one op per cycle.
//
// Ports:
//   clk, rst_n                       : clock, async active-low reset
//   req_valid / req_ready            : per-requester request handshake
//   req_operand_a/_b (64b slices)    : operands, slice i = requester i
//   req_alu_control (5b slices)      : op code
//   req_word_op                      : 32-bit W operation
//   rsp_valid / rsp_ready            : response handshake
//   rsp_id, rsp_result, rsp_zero,
//   rsp_err                          : response payload
//   grant_count (16b slices)         : saturating accepted-op counters
// ---------------------------------------------------------------------------
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*64-1:0] req_operand_a,
  input  logic [NUM_REQ*64-1:0] req_operand_b,
  input  logic [NUM_REQ*5-1:0]  req_alu_control,
  input  logic [NUM_REQ-1:0]    req_word_op,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [63:0]           rsp_result,
  output logic                  rsp_zero,
  output logic                  rsp_err,
  output logic [NUM_REQ*16-1:0] grant_count
);

  logic            r_rsp_valid;
  alu_rsp_t        r_rsp;
  logic [ID_W-1:0] r_ptr;
  logic [15:0]     r_cnt [NUM_REQ];

  logic [NUM_REQ-1:0] w_gnt;
  logic               w_slot_free;
  logic               w_accept;
  logic [ID_W-1:0]    w_idx;
  logic [63:0]        w_a;
  logic [63:0]        w_b;
  logic [4:0]         w_ctrl;
  logic               w_wop;
  logic [63:0]        w_alu_result;
  logic               w_alu_zero;
  logic               w_alu_err;
  alu_rsp_t           w_next;
  logic               w_unused_id;

  assign w_slot_free = !r_rsp_valid || rsp_ready;

  // rst_n gates the enable so no grant is visible while reset is asserted.
  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .i_en  (w_slot_free && rst_n),
    .o_gnt (w_gnt)
  );

  assign req_ready = w_gnt;
  assign w_accept  = |(w_gnt & req_valid);

  // One-hot grant selects the operands that drive the shared ALU.
  always_comb begin
    w_idx  = '0;
    w_a    = '0;
    w_b    = '0;
    w_ctrl = '0;
    w_wop  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_idx  = ID_W'(i);
        w_a    = req_operand_a[i*64 +: 64];
        w_b    = req_operand_b[i*64 +: 64];
        w_ctrl = req_alu_control[i*5 +: 5];
        w_wop  = req_word_op[i];
      end
    end
  end

  alu u_alu (
    .i_operand_a   (w_a),
    .i_operand_b   (w_b),
    .i_alu_control (w_ctrl),
    .i_word_op     (w_wop),
    .o_result      (w_alu_result),
    .o_zero        (w_alu_zero),
    .o_err         (w_alu_err)
  );

  always_comb begin
    w_next        = '0;
    w_next.id     = MAX_ID_W'(w_idx);
    w_next.result = w_alu_result;
    w_next.zero   = w_alu_zero;
    w_next.err    = w_alu_err;
  end

  // Response slot and RR pointer. The pointer only advances on accept, so
  // backpressure and idle cycles leave priority where it was.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp       <= '0;
      r_ptr       <= '0;
    end else begin
      if (w_accept) begin
        r_rsp       <= w_next;
        r_rsp_valid <= 1'b1;
        r_ptr       <= (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_idx + ID_W'(1);
      end else if (rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt[g] <= '0;
      end else if (w_gnt[g] && req_valid[g] && (r_cnt[g] != 16'hFFFF)) begin
        r_cnt[g] <= r_cnt[g] + 16'd1;
      end
    end
    assign grant_count[g*16 +: 16] = r_cnt[g];
  end

  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp.id[ID_W-1:0];
  assign rsp_result = r_rsp.result;
  assign rsp_zero   = r_rsp.zero;
  assign rsp_err    = r_rsp.err;

  // Upper id bits are constant zero when NUM_REQ == 2.
  assign w_unused_id = ^r_rsp.id;

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ID_W    = 1;

  logic                  clk;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*64-1:0] req_operand_a;
  logic [NUM_REQ*64-1:0] req_operand_b;
  logic [NUM_REQ*5-1:0]  req_alu_control;
  logic [NUM_REQ-1:0]    req_word_op;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [63:0]           rsp_result;
  logic                  rsp_zero;
  logic                  rsp_err;
  logic [NUM_REQ*16-1:0] grant_count;

  int vectors;
  int miscompares;

  alu_share_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_operand_a   (req_operand_a),
    .req_operand_b   (req_operand_b),
    .req_alu_control (req_alu_control),
    .req_word_op     (req_word_op),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_id          (rsp_id),
    .rsp_result      (rsp_result),
    .rsp_zero        (rsp_zero),
    .rsp_err         (rsp_err),
    .grant_count     (grant_count)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] ctrl, input logic wop);
    req_operand_a[i*64 +: 64] = a;
    req_operand_b[i*64 +: 64] = b;
    req_alu_control[i*5 +: 5] = ctrl;
    req_word_op[i]            = wop;
  endtask

  // Checks the full registered response.
  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 2'b11;
    #1;
    vectors++;
    if (req_ready !== 2'b00) begin
      miscompares++; $display("FAIL reset_req_ready: got %b expected 00", req_ready);
    end
    vectors++;
    if ({rsp_valid, rsp_id, rsp_zero, rsp_err} !== 4'b0000 || rsp_result !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_rsp: got v=%b id=%0d z=%b e=%b r=%h expected all zero",
               rsp_valid, rsp_id, rsp_zero, rsp_err, rsp_result);
    end
    vectors++;
    if (grant_count !== 32'd0) begin
      miscompares++; $display("FAIL reset_count: got %h expected 0", grant_count);
    end
    req_valid = 2'b00;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    set_req(0, 64'd5, 64'd7, 5'd0, 1'b0);
    req_valid = 2'b01;
    #1;
    vectors++;
    if (req_ready !== 2'b01) begin
      miscompares++; $display("FAIL single_ready: got %b expected 01", req_ready);
    end
    tick();
    req_valid = 2'b00;
    vectors++;
    if ({rsp_valid, rsp_id, rsp_zero, rsp_err} !== 4'b1000 || rsp_result !== 64'd12) begin
      miscompares++;
      $display("FAIL single_rsp: got v=%b id=%0d z=%b e=%b r=%h expected v=1 id=0 z=0 e=0 r=c",
               rsp_valid, rsp_id, rsp_zero, rsp_err, rsp_result);
    end
    vectors++;
    if (grant_count[15:0] !== 16'd1) begin
      miscompares++; $display("FAIL single_count: got %0d expected 1", grant_count[15:0]);
    end
    tick();
    vectors++;
    if (rsp_valid !== 1'b0 || rsp_result !== 64'd12) begin
      miscompares++;
      $display("FAIL single_drain: got v=%b r=%h expected v=0 r=c", rsp_valid, rsp_result);
    end
  endtask

  // Pointer sits at 1 after the single test, so grants run 1,0,1,0.
  task automatic test_contention();
    logic [1:0] exp_gnt [4];
    exp_gnt[0] = 2'b10; exp_gnt[1] = 2'b01; exp_gnt[2] = 2'b10; exp_gnt[3] = 2'b01;
    set_req(0, 64'd3, 64'd3, 5'd1, 1'b0);
    set_req(1, 64'hF, 64'h1, 5'd5, 1'b0);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      vectors++;
      if (req_ready !== exp_gnt[k]) begin
        miscompares++; $display("FAIL contention_gnt[%0d]: got %b expected %b", k, req_ready, exp_gnt[k]);
      end
      tick();
      vectors++;
      if (exp_gnt[k] == 2'b01) begin
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 64'd0 || rsp_zero !== 1'b1) begin
          miscompares++;
          $display("FAIL contention_rsp[%0d]: got v=%b id=%0d r=%h z=%b expected v=1 id=0 r=0 z=1",
                   k, rsp_valid, rsp_id, rsp_result, rsp_zero);
        end
      end else begin
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_result !== 64'hE || rsp_zero !== 1'b0) begin
          miscompares++;
          $display("FAIL contention_rsp[%0d]: got v=%b id=%0d r=%h z=%b expected v=1 id=1 r=e z=0",
                   k, rsp_valid, rsp_id, rsp_result, rsp_zero);
        end
      end
    end
    vectors++;
    if (grant_count !== {16'd2, 16'd3}) begin
      miscompares++; $display("FAIL contention_count: got %h expected 00020003", grant_count);
    end
  endtask

  // Slot holds id0/result0; pointer is 1 so release must grant requester 1.
  task automatic test_backpressure();
    rsp_ready = 1'b0;
    req_valid = 2'b11;
    for (int k = 0; k < 3; k++) begin
      #1;
      vectors++;
      if (req_ready !== 2'b00) begin
        miscompares++; $display("FAIL bp_ready[%0d]: got %b expected 00", k, req_ready);
      end
      tick();
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 64'd0) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: got v=%b id=%0d r=%h expected v=1 id=0 r=0", k, rsp_valid, rsp_id, rsp_result);
      end
    end
    vectors++;
    if (grant_count !== {16'd2, 16'd3}) begin
      miscompares++; $display("FAIL bp_count: got %h expected 00020003", grant_count);
    end
    rsp_ready = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 2'b10) begin
      miscompares++; $display("FAIL bp_release_gnt: got %b expected 10", req_ready);
    end
    tick();
    req_valid = 2'b00;
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_result !== 64'hE) begin
      miscompares++;
      $display("FAIL bp_reload: got v=%b id=%0d r=%h expected v=1 id=1 r=e", rsp_valid, rsp_id, rsp_result);
    end
    tick();
    vectors++;
    if (rsp_valid !== 1'b0 || rsp_result !== 64'hE) begin
      miscompares++; $display("FAIL bp_drain: got v=%b r=%h expected v=0 r=e", rsp_valid, rsp_result);
    end
  endtask

  task automatic test_word_op();
    set_req(0, 64'h7FFFFFFF, 64'd1, 5'd0, 1'b1);
    req_valid = 2'b01;
    tick();
    vectors++;
    if (rsp_result !== 64'hFFFFFFFF80000000 || rsp_err !== 1'b0 || rsp_zero !== 1'b0 || rsp_id !== 1'b0) begin
      miscompares++;
      $display("FAIL addw: got r=%h e=%b z=%b id=%0d expected r=ffffffff80000000 e=0 z=0 id=0",
               rsp_result, rsp_err, rsp_zero, rsp_id);
    end
    set_req(0, 64'd1, 64'd2, 5'd3, 1'b1);
    tick();
    req_valid = 2'b00;
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_result !== 64'd0 || rsp_zero !== 1'b1 || rsp_err !== 1'b1) begin
      miscompares++;
      $display("FAIL sltw_illegal: got v=%b r=%h z=%b e=%b expected v=1 r=0 z=1 e=1",
               rsp_valid, rsp_result, rsp_zero, rsp_err);
    end
    tick();
  endtask

  task automatic test_illegal();
    set_req(1, 64'h1234, 64'h5678, 5'b01111, 1'b0);
    req_valid = 2'b10;
    tick();
    req_valid = 2'b00;
    vectors++;
    if (rsp_id !== 1'b1 || rsp_result !== 64'd0 || rsp_err !== 1'b1 || rsp_zero !== 1'b1) begin
      miscompares++;
      $display("FAIL illegal_rsp: got id=%0d r=%h e=%b z=%b expected id=1 r=0 e=1 z=1",
               rsp_id, rsp_result, rsp_err, rsp_zero);
    end
    vectors++;
    if (grant_count !== {16'd4, 16'd5}) begin
      miscompares++; $display("FAIL illegal_count: got %h expected 00040005", grant_count);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [4:0]  t_ctrl [14];
    logic        t_wop  [14];
    logic [63:0] t_a    [14];
    logic [63:0] t_b    [14];
    logic [63:0] t_exp  [14];
    logic        t_err  [14];
    t_ctrl[0]  = 5'd1; t_wop[0]  = 0; t_a[0]  = 64'd0;                 t_b[0]  = 64'd1;  t_exp[0]  = 64'hFFFFFFFFFFFFFFFF; t_err[0]  = 0;
    t_ctrl[1]  = 5'd3; t_wop[1]  = 0; t_a[1]  = 64'hFFFFFFFFFFFFFFFF;  t_b[1]  = 64'd1;  t_exp[1]  = 64'd1;                t_err[1]  = 0;
    t_ctrl[2]  = 5'd4; t_wop[2]  = 0; t_a[2]  = 64'hFFFFFFFFFFFFFFFF;  t_b[2]  = 64'd1;  t_exp[2]  = 64'd0;                t_err[2]  = 0;
    t_ctrl[3]  = 5'd2; t_wop[3]  = 0; t_a[3]  = 64'd1;                 t_b[3]  = 64'd63; t_exp[3]  = 64'h8000000000000000; t_err[3]  = 0;
    t_ctrl[4]  = 5'd7; t_wop[4]  = 0; t_a[4]  = 64'h8000000000000000;  t_b[4]  = 64'd4;  t_exp[4]  = 64'hF800000000000000; t_err[4]  = 0;
    t_ctrl[5]  = 5'd6; t_wop[5]  = 0; t_a[5]  = 64'h8000000000000000;  t_b[5]  = 64'd4;  t_exp[5]  = 64'h0800000000000000; t_err[5]  = 0;
    t_ctrl[6]  = 5'd6; t_wop[6]  = 1; t_a[6]  = 64'h80000000;          t_b[6]  = 64'd4;  t_exp[6]  = 64'h0000000008000000; t_err[6]  = 0;
    t_ctrl[7]  = 5'd7; t_wop[7]  = 1; t_a[7]  = 64'h80000000;          t_b[7]  = 64'd4;  t_exp[7]  = 64'hFFFFFFFFF8000000; t_err[7]  = 0;
    t_ctrl[8]  = 5'd8; t_wop[8]  = 0; t_a[8]  = 64'hF0;                t_b[8]  = 64'h0F; t_exp[8]  = 64'hFF;               t_err[8]  = 0;
    t_ctrl[9]  = 5'd9; t_wop[9]  = 0; t_a[9]  = 64'hF0;                t_b[9]  = 64'h0F; t_exp[9]  = 64'd0;                t_err[9]  = 0;
    t_ctrl[10] = 5'd1; t_wop[10] = 1; t_a[10] = 64'd0;                 t_b[10] = 64'd1;  t_exp[10] = 64'hFFFFFFFFFFFFFFFF; t_err[10] = 0;
    t_ctrl[11] = 5'd2; t_wop[11] = 1; t_a[11] = 64'd1;                 t_b[11] = 64'd31; t_exp[11] = 64'hFFFFFFFF80000000; t_err[11] = 0;
    t_ctrl[12] = 5'd2; t_wop[12] = 1; t_a[12] = 64'd3;                 t_b[12] = 64'h20; t_exp[12] = 64'd3;                t_err[12] = 0;
    t_ctrl[13] = 5'd8; t_wop[13] = 1; t_a[13] = 64'hF0;                t_b[13] = 64'h0F; t_exp[13] = 64'd0;                t_err[13] = 1;
    req_valid = 2'b01;
    for (int k = 0; k < 14; k++) begin
      set_req(0, t_a[k], t_b[k], t_ctrl[k], t_wop[k]);
      #1;
      vectors++;
      if (req_ready !== 2'b01) begin
        miscompares++; $display("FAIL b2b_gnt[%0d]: got %b expected 01", k, req_ready);
      end
      tick();
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== t_exp[k] ||
          rsp_zero !== (t_exp[k] == 64'd0) || rsp_err !== t_err[k]) begin
        miscompares++;
        $display("FAIL b2b_rsp[%0d]: got v=%b id=%0d r=%h z=%b e=%b expected v=1 id=0 r=%h z=%b e=%b",
                 k, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err, t_exp[k], (t_exp[k] == 64'd0), t_err[k]);
      end
    end
    req_valid = 2'b00;
    tick();
    vectors++;
    if (grant_count !== {16'd4, 16'd19}) begin
      miscompares++; $display("FAIL b2b_count: got %h expected 00040013", grant_count);
    end
  endtask

  task automatic test_reset_mid();
    set_req(0, 64'd1, 64'd1, 5'd0, 1'b0);
    req_valid = 2'b01;
    tick();
    vectors++;
    if (rsp_valid !== 1'b1) begin
      miscompares++; $display("FAIL rstmid_pre: got v=%b expected 1", rsp_valid);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (rsp_valid !== 1'b0 || rsp_result !== 64'd0 || grant_count !== 32'd0 || req_ready !== 2'b00) begin
      miscompares++;
      $display("FAIL rstmid_clear: got v=%b r=%h cnt=%h rdy=%b expected v=0 r=0 cnt=0 rdy=00",
               rsp_valid, rsp_result, grant_count, req_ready);
    end
    tick();
    set_req(1, 64'd9, 64'd9, 5'd0, 1'b0);
    req_valid = 2'b11;
    rst_n = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 2'b01) begin
      miscompares++; $display("FAIL rstmid_first_gnt: got %b expected 01", req_ready);
    end
    tick();
    req_valid = 2'b00;
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 64'd2) begin
      miscompares++;
      $display("FAIL rstmid_rsp: got v=%b id=%0d r=%h expected v=1 id=0 r=2", rsp_valid, rsp_id, rsp_result);
    end
    tick();
  endtask

  initial begin
    vectors         = 0;
    miscompares     = 0;
    rst_n           = 1'b0;
    req_valid       = '0;
    req_operand_a   = '0;
    req_operand_b   = '0;
    req_alu_control = '0;
    req_word_op     = '0;
    rsp_ready       = 1'b1;
    tick();
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_word_op();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares one 64-bit ALU between NUM_REQ requesters, for example the main execute path, an address-generation unit and a debug/CSR helper. Each requester presents one operation on a valid/ready request channel. A round-robin arbiter grants one request per cycle and drives the shared ALU. The ALU output is registered into a single response slot, tagged with the grantee ID and returned on a valid/ready response channel.

Parameters:
NUM_REQ, 2, number of requesters; legal range 2..4.
ID_W, $clog2(NUM_REQ), width of the requester ID tag.

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst_n  in  1  reset; asynchronous, active-low
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
req_operand_a  in  NUM_REQ x 64  operand A, one slice per requester
req_operand_b  in  NUM_REQ x 64  operand B, one slice per requester
req_alu_control  in  NUM_REQ x 5  ALU operation code
req_word_op  in  NUM_REQ  1 = 32-bit W operation
rsp_valid  out  1  response slot holds a result
rsp_ready  in  1  consumer accepts the response
rsp_id  out  ID_W  index of the requester that issued the result
rsp_result  out  64  ALU result
rsp_zero  out  1  ALU zero flag
rsp_err  out  1  illegal op code/word_op combination
grant_count  out  NUM_REQ x 16  per-requester accepted-op counters, saturating

Behaviour:
- Reset (async assert, sync-safe deassert):
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, rsp_err=0.
  - RR pointer=0; all grant_count=0.
  - req_ready=0 while rst_n is low.
- Slot free condition: slot_free = !rsp_valid || rsp_ready.
- Arbitration (combinational):
  - If slot_free, grant the first requester with req_valid set, searching from the RR pointer upward with wrap-around.
  - req_ready is the one-hot grant, and is 0 when !slot_free.
  - req_ready never depends on the requester's own req_valid beyond the grant logic; no combinational path from rsp_ready to req_* other than through slot_free.
- Accept: a handshake occurs when req_valid[i] && req_ready[i].
  - The granted operands drive the internal ALU that same cycle.
  - On the next edge, the slot loads result, zero, err and id=i, and rsp_valid is set to 1.
  - Latency is exactly 1 cycle from accept to rsp_valid.
  - The RR pointer moves to (i+1) mod NUM_REQ only on accept.
- Drain: a response handshake is rsp_valid && rsp_ready.
  - With no accept in the same cycle, rsp_valid goes to 0 and the data fields hold their last values.
  - Drain plus accept in the same cycle: the slot reloads and rsp_valid stays 1. This gives full throughput of 1 op/cycle.
- Backpressure: while rsp_valid && !rsp_ready, the slot holds stable, no grants are issued, and the RR pointer holds.
- Error rule:
  - word_op=0: rsp_err=1 when alu_control is outside {0..9}.
  - word_op=1: rsp_err=1 when alu_control is outside {0,1,2,6,7}.
  - In both cases the op is still accepted and rsp_result is what the ALU returns (0).
- Counters: grant_count[i] increments on each accept by requester i and saturates at 16'hFFFF.
- Fairness: with all requesters continuously valid and rsp_ready=1, grants rotate 0,1,..,NUM_REQ-1, 0,...
- Reset mid-operation: a pending response is discarded and the counters clear.
- Requester protocol: requesters must hold req_* stable while valid and not granted. The block does not check this.

Decomposition:
- Package alu_pkg holds:
  - the 5-bit op-code localparams (ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9);
  - the function alu_op_legal(code, word_op);
  - the response struct type (id, result, zero, err).
- Sub-module rr_arbiter (NUM_REQ; inputs req, ptr, en; output one-hot gnt) holds the round-robin search.
- The existing ALU module is instantiated once internally.

Test Plan:
- Single request: req0 ADD, A=5, B=7, rsp_ready=1 -> next cycle rsp_valid=1, id=0, result=12, zero=0, err=0.
- Contention: both requesters valid every cycle (req0 SUB 3-3, req1 XOR 0xF^0x1) -> grants alternate 0,1,0,1; req0 responses result=0 with zero=1; req1 responses result=0xE.
- Backpressure: rsp_ready=0 for 3 cycles with req1 valid -> response slot stable, req_ready=0, pointer unchanged; rsp_ready=1 -> drain and req1 accepted the same cycle; rsp_valid remains 1.
- Word op: word_op=1, ADDW, A=0x7FFFFFFF, B=1 -> result=0xFFFFFFFF80000000, err=0. Then word_op=1, SLT (code 3) -> result=0, zero=1, err=1.
- Illegal 64-bit code 5'b01111 -> result=0, err=1; grant_count for that requester increments.
- Reset mid-flight: rst_n low while rsp_valid=1 -> immediately rsp_valid=0 and counters=0; after release, the first grant goes to requester 0.
